// File: rtl/response_framer.sv
// response_framer: buffers the answering unit's param words and emits one framed response
// (header + params) per cmd_done, arbitrating involuntary requests round-robin. Define RSP_CHECKSUM_EN for an XOR trailer.
module response_framer #(
  parameter int NUNITS      = 4,
  parameter int PARAM_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [33*NUNITS-1:0]      unit_param_data,
  input  logic [NUNITS-1:0]         unit_param_write,
  input  logic [NUNITS-1:0]         unit_cmd_done,
  input  logic [NUNITS-1:0]         unit_invol_req,
  output logic [NUNITS-1:0]         unit_invol_grant,
  input  logic                      cmd_busy,
  input  logic [$clog2(NUNITS)-1:0] cmd_unit,
  output logic                      framer_busy,
  output logic [31:0]               msg_data,
  output logic                      msg_tag,
  output logic                      msg_valid,
  output logic                      msg_last,
  input  logic                      msg_ready
);
  localparam int UW = $clog2(NUNITS);
  localparam int SW = UW + 1;
  localparam int AW = $clog2(PARAM_DEPTH);
  localparam int CW = $clog2(PARAM_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(PARAM_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [SW-1:0] NU_C    = SW'(NUNITS);
`ifdef RSP_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    COLLECT = 3'd2,
    HEADER  = 3'd3,
    PAYLOAD = 3'd4,
    TRAILER = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [UW-1:0]     src, rr, pick;
  logic              pick_found;
  logic [SW-1:0]     scan;
  logic [CW-1:0]     count, rd_idx;
  logic              overflow;
  logic [32:0]       mem [PARAM_DEPTH];
  logic [32:0]       src_data, rd_word;
  logic              src_write, src_done, push_en, accept;
  logic [31:0]       header, csum;
  logic [31:0]       nxt_data, nxt_csum;
  logic              nxt_valid, nxt_tag, nxt_last;
  logic [NUNITS-1:0] nxt_grant;

  function automatic logic [UW-1:0] wrap_inc(input logic [UW-1:0] v);
    if (v == UW'(NUNITS - 1)) return {UW{1'b0}};
    else return v + UW'(1);
  endfunction

  function automatic logic [31:0] csum_fold(input logic [31:0] acc, input logic [32:0] word);
    return acc ^ word[31:0];
  endfunction

  // Only the current source unit is observed; everyone else's strobes are ignored.
  assign src_data  = unit_param_data[32'd33 * int'(src) +: 33];
  assign src_write = unit_param_write[src];
  assign src_done  = unit_cmd_done[src];
  assign push_en   = (state == COLLECT) && src_write && !src_done && (count < DEPTH_C);
  assign accept    = msg_valid && msg_ready;
  assign rd_word   = mem[rd_idx[AW-1:0]];
  assign header    = {src_data[7:0], 8'(count), overflow, 7'b0000000, 8'(src)};

  // Round-robin search: first requester at or after rr.
  always_comb begin
    pick       = rr;
    pick_found = 1'b0;
    scan       = {SW{1'b0}};
    for (int k = 0; k < NUNITS; k++) begin
      scan = {1'b0, rr} + SW'(k);
      if (scan >= NU_C) scan = scan - NU_C;
      else scan = scan;
      if (!pick_found && unit_invol_req[scan[UW-1:0]]) begin
        pick       = scan[UW-1:0];
        pick_found = 1'b1;
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; HEADER and PAYLOAD share the same "load next word" rule.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_busy)        next_state = COLLECT;
        else if (pick_found) next_state = GRANT;
        else                 next_state = IDLE;
      end
      GRANT:   next_state = COLLECT;
      COLLECT: begin
        if (src_done) next_state = HEADER;
        else          next_state = COLLECT;
      end
      HEADER, PAYLOAD: begin
        if (!accept)              next_state = state;
        else if (rd_idx != count) next_state = PAYLOAD;
        else if (CK_EN)           next_state = TRAILER;
        else                      next_state = IDLE;
      end
      TRAILER: begin
        if (accept) next_state = IDLE;
        else        next_state = TRAILER;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered output beat; a beat is only replaced once accepted.
  always_comb begin
    nxt_valid = msg_valid;
    nxt_data  = msg_data;
    nxt_tag   = msg_tag;
    nxt_last  = msg_last;
    nxt_csum  = csum;
    nxt_grant = {NUNITS{1'b0}};
    case (state)
      IDLE: begin
        if (!cmd_busy && pick_found) nxt_grant = NUNITS'(1) << pick;
        else                         nxt_grant = {NUNITS{1'b0}};
      end
      COLLECT: begin
        if (src_done) begin
          nxt_valid = 1'b1;
          nxt_data  = header;
          nxt_tag   = 1'b0;
          nxt_last  = (count == {CW{1'b0}}) && !CK_EN;
          nxt_csum  = header;
        end else begin
          nxt_valid = 1'b0;
        end
      end
      HEADER, PAYLOAD: begin
        if (accept && (rd_idx != count)) begin
          nxt_valid = 1'b1;
          nxt_data  = rd_word[31:0];
          nxt_tag   = rd_word[32];
          nxt_last  = ((rd_idx + ONE_C) == count) && !CK_EN;
          nxt_csum  = csum_fold(csum, rd_word);
        end else if (accept && CK_EN) begin
          nxt_valid = 1'b1;
          nxt_data  = csum;
          nxt_tag   = 1'b0;
          nxt_last  = 1'b1;
        end else if (accept) begin
          nxt_valid = 1'b0;
          nxt_data  = 32'h0000_0000;
          nxt_tag   = 1'b0;
          nxt_last  = 1'b0;
        end else begin
          nxt_valid = msg_valid;
        end
      end
      TRAILER: begin
        if (accept) begin
          nxt_valid = 1'b0;
          nxt_data  = 32'h0000_0000;
          nxt_tag   = 1'b0;
          nxt_last  = 1'b0;
        end else begin
          nxt_valid = msg_valid;
        end
      end
      default: begin
        nxt_valid = 1'b0;
        nxt_data  = 32'h0000_0000;
        nxt_tag   = 1'b0;
        nxt_last  = 1'b0;
      end
    endcase
  end

  // Output, arbitration and FIFO bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_valid        <= 1'b0;
      msg_data         <= 32'h0000_0000;
      msg_tag          <= 1'b0;
      msg_last         <= 1'b0;
      csum             <= 32'h0000_0000;
      unit_invol_grant <= {NUNITS{1'b0}};
      framer_busy      <= 1'b0;
      count            <= {CW{1'b0}};
      rd_idx           <= {CW{1'b0}};
      overflow         <= 1'b0;
      src              <= {UW{1'b0}};
      rr               <= {UW{1'b0}};
    end else begin
      msg_valid        <= nxt_valid;
      msg_data         <= nxt_data;
      msg_tag          <= nxt_tag;
      msg_last         <= nxt_last;
      csum             <= nxt_csum;
      unit_invol_grant <= nxt_grant;
      framer_busy      <= (next_state != IDLE);
      if (state == IDLE) begin
        count    <= {CW{1'b0}};
        rd_idx   <= {CW{1'b0}};
        overflow <= 1'b0;
        if (cmd_busy) begin
          src <= cmd_unit;
        end else if (pick_found) begin
          src <= pick;
          rr  <= wrap_inc(pick);
        end
      end else if (state == COLLECT) begin
        if (push_en) count <= count + ONE_C;
        if ((state == COLLECT) && src_write && !src_done && (count == DEPTH_C)) overflow <= 1'b1;
      end else if ((state == HEADER || state == PAYLOAD) && accept && (rd_idx != count)) begin
        rd_idx <= rd_idx + ONE_C;
      end
    end
  end

  // Param storage; cleared logically by resetting count.
  always_ff @(posedge clk) begin
    if (push_en) mem[count[AW-1:0]] <= src_data;
  end
endmodule
